// File: rtl/mmio_bus_router.sv
// Single-master AXI4 router from the core MMIO port to a few peripheral slots.
// One transaction at a time; unmapped or depopulated slots are answered locally with DECERR.
module mmio_bus_router #(
  parameter int                   NUM_SLOTS  = 3,
  parameter logic [30:0]          BASE_ADDR  = 31'h6000_0000,
  parameter int                   SLOT_SHIFT = 16,
  parameter logic [NUM_SLOTS-1:0] SLOT_EN    = 3'b001
) (
  input  logic                     clock,
  input  logic                     resetn,

  input  logic                     s_aw_valid,
  output logic                     s_aw_ready,
  input  logic [47:0]              s_aw_bits,
  input  logic                     s_w_valid,
  output logic                     s_w_ready,
  input  logic [40:0]              s_w_bits,
  output logic                     s_b_valid,
  input  logic                     s_b_ready,
  output logic [5:0]               s_b_bits,
  input  logic                     s_ar_valid,
  output logic                     s_ar_ready,
  input  logic [47:0]              s_ar_bits,
  output logic                     s_r_valid,
  input  logic                     s_r_ready,
  output logic [38:0]              s_r_bits,

  output logic [NUM_SLOTS-1:0]     m_aw_valid,
  input  logic [NUM_SLOTS-1:0]     m_aw_ready,
  output logic [47:0]              m_aw_bits,
  output logic [NUM_SLOTS-1:0]     m_w_valid,
  input  logic [NUM_SLOTS-1:0]     m_w_ready,
  output logic [40:0]              m_w_bits,
  input  logic [NUM_SLOTS-1:0]     m_b_valid,
  output logic [NUM_SLOTS-1:0]     m_b_ready,
  input  logic [6*NUM_SLOTS-1:0]   m_b_bits,
  output logic [NUM_SLOTS-1:0]     m_ar_valid,
  input  logic [NUM_SLOTS-1:0]     m_ar_ready,
  output logic [47:0]              m_ar_bits,
  input  logic [NUM_SLOTS-1:0]     m_r_valid,
  output logic [NUM_SLOTS-1:0]     m_r_ready,
  input  logic [39*NUM_SLOTS-1:0]  m_r_bits
);

  localparam int MATCH_LSB = SLOT_SHIFT + 2;
  localparam int ADDR_LSB  = 13;

  typedef enum logic [3:0] {
    IDLE, WA, WD, WB, RA, RD, WERR, EB, RERR
  } state_t;

  state_t      state_q, state_d;
  logic        rd_prio_q, rd_prio_d;
  logic [47:0] abits_q, abits_d;
  logic [1:0]  slot_q, slot_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        idle;
  logic        grant_rd, grant_wr;
  logic [47:0] in_bits;
  logic        in_hit;
  logic [1:0]  in_slot;
  logic        in_err;
  logic [3:0]  slot_en_ext;

  logic [NUM_SLOTS-1:0] slot_oh;
  logic        sel_aw_ready, sel_w_ready, sel_ar_ready;
  logic        sel_b_valid, sel_r_valid;
  logic [5:0]  sel_b_bits;
  logic [38:0] sel_r_bits;

  // Address readiness is gated by resetn so nothing handshakes while reset is held.
  assign idle     = (state_q == IDLE) && resetn;
  assign grant_rd = idle && s_ar_valid && (!s_aw_valid || rd_prio_q);
  assign grant_wr = idle && s_aw_valid && !grant_rd;
  assign in_bits  = grant_rd ? s_ar_bits : s_aw_bits;

  assign slot_en_ext = 4'(SLOT_EN);
  assign in_hit  = (in_bits[ADDR_LSB+30:ADDR_LSB+MATCH_LSB] == BASE_ADDR[30:MATCH_LSB]);
  assign in_slot = in_bits[ADDR_LSB+SLOT_SHIFT+1:ADDR_LSB+SLOT_SHIFT];
  assign in_err  = !in_hit || (int'(in_slot) >= NUM_SLOTS) || !slot_en_ext[in_slot];

  // Select the handshake and response inputs of the slot owning the current transaction.
  always_comb begin
    slot_oh      = '0;
    sel_aw_ready = 1'b0;
    sel_w_ready  = 1'b0;
    sel_ar_ready = 1'b0;
    sel_b_valid  = 1'b0;
    sel_r_valid  = 1'b0;
    sel_b_bits   = '0;
    sel_r_bits   = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (slot_q == 2'(k)) begin
        slot_oh[k]   = 1'b1;
        sel_aw_ready = m_aw_ready[k];
        sel_w_ready  = m_w_ready[k];
        sel_ar_ready = m_ar_ready[k];
        sel_b_valid  = m_b_valid[k];
        sel_r_valid  = m_r_valid[k];
        sel_b_bits   = m_b_bits[6*k +: 6];
        sel_r_bits   = m_r_bits[39*k +: 39];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      rd_prio_q <= 1'b1;
      abits_q   <= '0;
      slot_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_prio_q <= rd_prio_d;
      abits_q   <= abits_d;
      slot_q    <= slot_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_prio_d = rd_prio_q;
    abits_d   = abits_q;
    slot_d    = slot_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_rd || grant_wr) begin
          abits_d   = in_bits;
          slot_d    = in_slot;
          cnt_d     = in_bits[12:5];
          rd_prio_d = grant_wr;
          if (grant_rd) state_d = in_err ? RERR : RA;
          else          state_d = in_err ? WERR : WA;
        end
      end
      WA:   if (sel_aw_ready) state_d = WD;
      WD:   if (s_w_valid && sel_w_ready && s_w_bits[0]) state_d = WB;
      WB:   if (sel_b_valid && s_b_ready) state_d = IDLE;
      RA:   if (sel_ar_ready) state_d = RD;
      RD:   if (sel_r_valid && s_r_ready && sel_r_bits[0]) state_d = IDLE;
      WERR: if (s_w_valid && s_w_bits[0]) state_d = EB;
      EB:   if (s_b_ready) state_d = IDLE;
      RERR: begin
        if (s_r_ready) begin
          if (cnt_q == 8'd0) state_d = IDLE;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Non-selected slots never see valid or ready; payloads are broadcast.
  always_comb begin
    s_aw_ready = grant_wr;
    s_ar_ready = grant_rd;
    s_w_ready  = 1'b0;
    s_b_valid  = 1'b0;
    s_b_bits   = '0;
    s_r_valid  = 1'b0;
    s_r_bits   = '0;
    m_aw_valid = '0;
    m_w_valid  = '0;
    m_b_ready  = '0;
    m_ar_valid = '0;
    m_r_ready  = '0;
    m_aw_bits  = abits_q;
    m_ar_bits  = abits_q;
    m_w_bits   = s_w_bits;
    case (state_q)
      WA: m_aw_valid = slot_oh;
      WD: begin
        m_w_valid = s_w_valid ? slot_oh : '0;
        s_w_ready = sel_w_ready;
      end
      WB: begin
        s_b_valid = sel_b_valid;
        s_b_bits  = sel_b_bits;
        m_b_ready = s_b_ready ? slot_oh : '0;
      end
      RA: m_ar_valid = slot_oh;
      RD: begin
        s_r_valid = sel_r_valid;
        s_r_bits  = sel_r_bits;
        m_r_ready = s_r_ready ? slot_oh : '0;
      end
      WERR: s_w_ready = 1'b1;
      EB: begin
        s_b_valid = 1'b1;
        s_b_bits  = {abits_q[47:44], 2'b11};
      end
      RERR: begin
        s_r_valid = 1'b1;
        s_r_bits  = {abits_q[47:44], 32'h0, 2'b11, (cnt_q == 8'd0)};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mmio_bus_router.sv
// Directed and randomized bench for mmio_bus_router; the bench plays both master and slots
// and predicts routing from the address map with plain arithmetic.
module tb_mmio_bus_router;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic        s_aw_valid = 0, s_aw_ready;
  logic [47:0] s_aw_bits = '0;
  logic        s_w_valid = 0, s_w_ready;
  logic [40:0] s_w_bits = '0;
  logic        s_b_valid, s_b_ready = 0;
  logic [5:0]  s_b_bits;
  logic        s_ar_valid = 0, s_ar_ready;
  logic [47:0] s_ar_bits = '0;
  logic        s_r_valid, s_r_ready = 0;
  logic [38:0] s_r_bits;
  logic [2:0]  m_aw_valid, m_aw_ready = '0;
  logic [47:0] m_aw_bits;
  logic [2:0]  m_w_valid, m_w_ready = '0;
  logic [40:0] m_w_bits;
  logic [2:0]  m_b_valid = '0, m_b_ready;
  logic [17:0] m_b_bits = '0;
  logic [2:0]  m_ar_valid, m_ar_ready = '0;
  logic [47:0] m_ar_bits;
  logic [2:0]  m_r_valid = '0, m_r_ready;
  logic [116:0] m_r_bits = '0;

  int tests_run = 0;
  int tests_failed = 0;

  mmio_bus_router dut (
    .clock(clock), .resetn(resetn),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_bits(s_aw_bits),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_bits(s_w_bits),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_bits(s_b_bits),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_bits(s_ar_bits),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_bits(s_r_bits),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_bits(m_aw_bits),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_bits(m_w_bits),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_bits(m_b_bits),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_bits(m_ar_bits),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_bits(m_r_bits)
  );

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [47:0] pack_a(input logic [3:0] id, input logic [30:0] addr,
                                         input logic [7:0] len);
    return {id, addr, len, 3'd2, 2'd1};
  endfunction

  // Address map: 64 KiB slots above 0x6000_0000, only slot 0 populated.
  function automatic int model_slot(input logic [30:0] addr);
    return int'((addr >> 16) & 31'd3);
  endfunction

  function automatic logic model_err(input logic [30:0] addr);
    logic [3:0] en;
    int slot;
    logic hit;
    en   = 4'b0001;
    slot = model_slot(addr);
    hit  = ((addr >> 18) == (31'h6000_0000 >> 18));
    return !hit || (slot >= 3) || !en[slot];
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [30:0] addr, input int len,
                          input logic [1:0] resp, input int aw_wait, input int b_delay,
                          input bit fixed);
    logic [47:0] a;
    logic        err;
    int          slot;
    logic [2:0]  oh;
    logic [40:0] w;
    a    = pack_a(id, addr, len[7:0]);
    err  = model_err(addr);
    slot = model_slot(addr);
    oh   = err ? 3'b000 : 3'(1 << slot);
    s_aw_valid = 1; s_aw_bits = a;
    #1;
    check_output("wr_aw_ready", 64'(s_aw_ready), 64'(1));
    check_output("wr_aw_not_early", 64'(m_aw_valid), 64'(0));
    tick();
    s_aw_valid = 0; s_aw_bits = '0;
    #1;
    check_output("wr_m_aw_valid", 64'(m_aw_valid), 64'(oh));
    if (!err) begin
      check_output("wr_m_aw_bits", 64'(m_aw_bits), 64'(a));
      for (int i = 0; i < aw_wait; i++) begin
        tick();
        check_output("wr_m_aw_hold", 64'(m_aw_valid), 64'(oh));
      end
      m_aw_ready = oh;
      tick();
      m_aw_ready = '0;
    end
    for (int i = 0; i <= len; i++) begin
      w = {(fixed ? 32'hA5A5_A5A5 : 32'($urandom)), (fixed ? 8'h0F : 8'($urandom)), (i == len)};
      s_w_valid = 1; s_w_bits = w; m_w_ready = oh;
      #1;
      check_output("wr_s_w_ready", 64'(s_w_ready), 64'(1));
      check_output("wr_m_w_valid", 64'(m_w_valid), 64'(oh));
      if (!err) check_output("wr_m_w_bits", 64'(m_w_bits), 64'(w));
      tick();
    end
    s_w_valid = 0; m_w_ready = '0;
    if (!err) begin
      for (int i = 0; i < b_delay; i++) begin
        #1;
        check_output("wr_b_wait", 64'(s_b_valid), 64'(0));
        tick();
      end
      m_b_valid = oh;
      m_b_bits = 18'($urandom);
      m_b_bits[6*slot +: 6] = {id, resp};
      #1;
      check_output("wr_s_b_valid", 64'(s_b_valid), 64'(1));
      check_output("wr_s_b_bits", 64'(s_b_bits), 64'({id, resp}));
      s_b_ready = 1;
      #1;
      check_output("wr_m_b_ready", 64'(m_b_ready), 64'(oh));
      tick();
      m_b_valid = '0; s_b_ready = 0;
    end else begin
      #1;
      check_output("wr_err_b_valid", 64'(s_b_valid), 64'(1));
      check_output("wr_err_b_bits", 64'(s_b_bits), 64'({id, 2'b11}));
      s_b_ready = 1;
      #1;
      check_output("wr_err_m_b_ready", 64'(m_b_ready), 64'(0));
      tick();
      s_b_ready = 0;
    end
    #1;
    check_output("wr_done_b_valid", 64'(s_b_valid), 64'(0));
    check_output("wr_done_w_ready", 64'(s_w_ready), 64'(0));
  endtask

  task automatic do_read(input logic [3:0] id, input logic [30:0] addr, input int len,
                         input int ar_wait, input int stall_beat, input int stall_cycles,
                         input bit fixed);
    logic [47:0] a;
    logic        err;
    int          slot;
    logic [2:0]  oh;
    logic [38:0] r;
    a    = pack_a(id, addr, len[7:0]);
    err  = model_err(addr);
    slot = model_slot(addr);
    oh   = err ? 3'b000 : 3'(1 << slot);
    s_ar_valid = 1; s_ar_bits = a;
    #1;
    check_output("rd_ar_ready", 64'(s_ar_ready), 64'(1));
    tick();
    s_ar_valid = 0; s_ar_bits = '0;
    #1;
    check_output("rd_m_ar_valid", 64'(m_ar_valid), 64'(oh));
    if (!err) begin
      check_output("rd_m_ar_bits", 64'(m_ar_bits), 64'(a));
      check_output("rd_no_early_r", 64'(s_r_valid), 64'(0));
      check_output("rd_no_early_m_r_ready", 64'(m_r_ready), 64'(0));
      for (int i = 0; i < ar_wait; i++) begin
        tick();
        check_output("rd_m_ar_hold", 64'(m_ar_valid), 64'(oh));
      end
      m_ar_ready = oh;
      tick();
      m_ar_ready = '0;
      for (int i = 0; i <= len; i++) begin
        r = {id, (fixed ? 32'((i + 1) * 32'h11) : 32'($urandom)),
             (fixed ? 2'b00 : 2'($urandom)), (i == len)};
        m_r_valid = oh;
        m_r_bits = 117'($urandom);
        m_r_bits[39*slot +: 39] = r;
        s_r_ready = 0;
        if (i == stall_beat) begin
          for (int c = 0; c < stall_cycles; c++) begin
            #1;
            check_output("rd_stall_valid", 64'(s_r_valid), 64'(1));
            check_output("rd_stall_m_r_ready", 64'(m_r_ready), 64'(0));
            tick();
          end
        end
        s_r_ready = 1;
        #1;
        check_output("rd_s_r_valid", 64'(s_r_valid), 64'(1));
        check_output("rd_s_r_bits", 64'(s_r_bits), 64'(r));
        check_output("rd_m_r_ready", 64'(m_r_ready), 64'(oh));
        tick();
      end
      m_r_valid = '0; s_r_ready = 0;
    end else begin
      for (int i = 0; i <= len; i++) begin
        s_r_ready = 1;
        #1;
        check_output("rd_err_valid", 64'(s_r_valid), 64'(1));
        check_output("rd_err_bits", 64'(s_r_bits), 64'({id, 32'h0, 2'b11, (i == len)}));
        check_output("rd_err_m_ar", 64'(m_ar_valid), 64'(0));
        tick();
      end
      s_r_ready = 0;
    end
    #1;
    check_output("rd_done_valid", 64'(s_r_valid), 64'(0));
  endtask

  initial begin
    #500_000;
    $error("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [30:0] addr;
    int          region;

    // Reset state, with address requests already presented.
    s_aw_valid = 1; s_ar_valid = 1;
    s_aw_bits = pack_a(4'h1, 31'h6000_0000, 8'd0);
    s_ar_bits = pack_a(4'h2, 31'h6000_0000, 8'd0);
    #2;
    check_output("rst_aw_ready", 64'(s_aw_ready), 64'(0));
    check_output("rst_ar_ready", 64'(s_ar_ready), 64'(0));
    check_output("rst_valids", 64'({s_b_valid, s_r_valid, s_w_ready, m_aw_valid, m_ar_valid,
                                    m_w_valid, m_b_ready, m_r_ready}), 64'(0));
    check_output("rst_aw_bits", 64'(m_aw_bits), 64'(0));
    s_aw_valid = 0; s_ar_valid = 0;
    tick();
    resetn = 1;
    tick();

    // Directed write, slot 0, B two cycles after WLAST.
    do_write(4'h9, 31'h6000_0004, 0, 2'b00, 0, 2, 1'b1);
    // Directed read burst with a two-cycle master stall.
    do_read(4'h4, 31'h6000_0010, 3, 1, 2, 2, 1'b1);
    // Depopulated slot 1 read and out-of-window write.
    do_read(4'hB, 31'h6001_0000, 1, 0, -1, 0, 1'b0);
    do_write(4'hC, 31'h7000_0000, 2, 2'b00, 0, 0, 1'b0);
    // Longest local error burst: 256 beats.
    do_read(4'h7, 31'h6002_0000, 255, 0, -1, 0, 1'b0);

    // Arbitration: fresh reset favours read, then the alternation favours write.
    resetn = 0;
    tick();
    resetn = 1;
    tick();
    s_aw_valid = 1; s_aw_bits = pack_a(4'h3, 31'h7000_0000, 8'd0);
    s_ar_valid = 1; s_ar_bits = pack_a(4'h5, 31'h7000_0000, 8'd0);
    #1;
    check_output("arb1_ar_ready", 64'(s_ar_ready), 64'(1));
    check_output("arb1_aw_ready", 64'(s_aw_ready), 64'(0));
    tick();
    s_ar_valid = 0;
    #1;
    check_output("arb1_aw_busy", 64'(s_aw_ready), 64'(0));
    check_output("arb1_r_bits", 64'(s_r_bits), 64'({4'h5, 32'h0, 2'b11, 1'b1}));
    s_r_ready = 1;
    tick();
    s_r_ready = 0;
    s_ar_valid = 1; s_ar_bits = pack_a(4'h6, 31'h7000_0000, 8'd0);
    #1;
    check_output("arb2_aw_ready", 64'(s_aw_ready), 64'(1));
    check_output("arb2_ar_ready", 64'(s_ar_ready), 64'(0));
    tick();
    s_aw_valid = 0;
    s_w_valid = 1; s_w_bits = {32'h1234_5678, 8'hFF, 1'b1};
    #1;
    check_output("arb2_w_ready", 64'(s_w_ready), 64'(1));
    check_output("arb2_ar_busy", 64'(s_ar_ready), 64'(0));
    tick();
    s_w_valid = 0;
    #1;
    check_output("arb2_b_bits", 64'({s_b_valid, s_b_bits}), 64'({1'b1, 4'h3, 2'b11}));
    s_b_ready = 1;
    tick();
    s_b_ready = 0;
    #1;
    check_output("arb3_ar_ready", 64'(s_ar_ready), 64'(1));
    tick();
    s_ar_valid = 0;
    #1;
    check_output("arb3_r_bits", 64'({s_r_valid, s_r_bits}), 64'({1'b1, 4'h6, 32'h0, 2'b11, 1'b1}));
    s_r_ready = 1;
    tick();
    s_r_ready = 0;
    #1;
    check_output("arb3_done", 64'(s_r_valid), 64'(0));

    // Reset dropped during the second beat of a slot-0 read.
    tick();
    s_ar_valid = 1; s_ar_bits = pack_a(4'hA, 31'h6000_0020, 8'd3);
    tick();
    s_ar_valid = 0;
    m_ar_ready = 3'b001;
    tick();
    m_ar_ready = '0;
    m_r_valid = 3'b001; m_r_bits = '0; m_r_bits[38:0] = {4'hA, 32'hDEAD_0001, 2'b00, 1'b0};
    s_r_ready = 1;
    tick();
    m_r_bits[38:0] = {4'hA, 32'hDEAD_0002, 2'b00, 1'b0};
    #1;
    check_output("mid_beat2_fwd", 64'(s_r_bits), 64'({4'hA, 32'hDEAD_0002, 2'b00, 1'b0}));
    resetn = 0;
    #1;
    check_output("mid_rst_outputs", 64'({s_r_valid, m_r_ready, s_aw_ready, s_ar_ready, s_w_ready,
                                         s_b_valid, m_aw_valid, m_ar_valid, m_w_valid, m_b_ready}),
                 64'(0));
    tick();
    resetn = 1;
    #1;
    check_output("post_rst_stale_r", 64'(s_r_valid), 64'(0));
    check_output("post_rst_stale_ready", 64'(m_r_ready), 64'(0));
    tick();
    do_read(4'hD, 31'h6000_0040, 0, 0, -1, 0, 1'b0);

    // Randomized traffic over the address map.
    for (int t = 0; t < 40; t++) begin
      region = int'($urandom_range(0, 5));
      if (region < 4)       addr = 31'h6000_0000 | 31'(region << 16) | 31'($urandom & 32'hFFFC);
      else if (region == 4) addr = 31'h7000_0000 | 31'($urandom & 32'h00FF_FFFC);
      else                  addr = 31'h1000_0000 | 31'($urandom & 32'h0FFF_FFFC);
      if ($urandom_range(0, 1) == 1)
        do_write(4'($urandom), addr, int'($urandom_range(0, 4)), 2'($urandom),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0);
      else
        do_read(4'($urandom), addr, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
